clr_req_qualifier: RTL and testbench
====================================

// Module: clr_req_qualifier
// PURPOSE
//  Upstream qualifier for the state-register stage's clear request input 'a'.
//  Synchronises an asynchronous raw request and debounces it on press and on release.
//  Emits exactly one single-cycle clear pulse per qualified press; a holdoff window follows each release.
//  Also keeps a wrapping count of issued pulses for the position/trace logic.
// PARAMETERS
//  DEB_CYCLES      4  consecutive synchronised samples needed to qualify press/release (>=2)
//  HOLDOFF_CYCLES  8  cycles after qualified release during which input is ignored (>=1)
//  CNT_W           4  width of evt_cnt
// PORTS
//  clk        in   1      single clock, all logic rising-edge
//  rst        in   1      synchronous, active-high reset
//  raw_in     in   1      asynchronous raw clear request
//  en         in   1      qualifier enable; low forces IDLE
//  pulse_out  out  1      one-cycle qualified clear pulse (drives downstream 'a')
//  level      out  1      1 while in ACTIVE (request held and qualified)
//  busy       out  1      1 whenever state != IDLE
//  evt_cnt    out  CNT_W  pulses issued, modulo 2^CNT_W
// BEHAVIOUR
//  Reset: sync flops=0, state=IDLE, press/release/holdoff counters=0, pulse_out=0, level=0, busy=0, evt_cnt=0.
//  Reset mid-operation: any pending pulse is dropped. State returns to IDLE on the next edge.
//  Sync: 2-flop synchroniser raw_in->s. s lags raw_in by 2 edges.
//  All outputs are registered.
//  FSM states IDLE, CONFIRM, ACTIVE, HOLDOFF:
//   IDLE:    en&&s -> CONFIRM, press_cnt=1. Otherwise stay.
//   CONFIRM: !s -> IDLE, press_cnt=0.
//            s && press_cnt==DEB_CYCLES-1 -> ACTIVE, pulse_out=1 for that one cycle, evt_cnt+=1.
//            Otherwise press_cnt+=1.
//   ACTIVE:  s -> rel_cnt=0.
//            !s && rel_cnt==DEB_CYCLES-1 -> HOLDOFF, hold_cnt=0.
//            Otherwise, while !s, rel_cnt+=1.
//   HOLDOFF: ignores s. hold_cnt+=1; when hold_cnt==HOLDOFF_CYCLES-1 -> IDLE (exactly HOLDOFF_CYCLES cycles).
//            If s is still 1 on return to IDLE, a new qualification starts (a new pulse is allowed).
//  en low in any state: next state IDLE, all counters cleared, no pulse. evt_cnt holds its value.
//  Latency: raw_in sampled 1 at edge E0 and held stable -> pulse_out=1 in the cycle after edge E0+DEB_CYCLES+1.
//  Pulse width: exactly 1 cycle, at most one pulse per ACTIVE entry.
//  A single-cycle glitch on s during CONFIRM aborts to IDLE. During ACTIVE it only restarts rel_cnt.
//  evt_cnt wraps 2^CNT_W-1 -> 0 silently.
//  level=1 exactly in ACTIVE. busy=1 in CONFIRM, ACTIVE and HOLDOFF.
// TESTING (defaults unless stated)
//  1. rst 3 cycles, then idle -> all outputs 0, evt_cnt=0.
//  2. raw_in 0->1 sampled at edge 10, held -> pulse_out=1 only in the cycle after edge 15; level=1 from then on; evt_cnt=1.
//  3. raw_in high for 3 edges then low -> no pulse; state back to IDLE; busy drops.
//  4. Qualified press, release held low 4 samples -> HOLDOFF for 8 cycles.
//     Raw bouncing during HOLDOFF -> no pulse.
//     Raw held high past holdoff -> second pulse; evt_cnt=2.
//  5. 16 qualified presses -> evt_cnt wraps to 0. en=0 mid-CONFIRM -> IDLE, no pulse, evt_cnt unchanged.
//  6. rst asserted in the same cycle CONFIRM would qualify -> no pulse_out, evt_cnt=0, IDLE next cycle.

Source files
------------

// File: rtl/clr_req_qualifier.sv
// Clear-request qualifier: synchronises raw_in, debounces press and release,
// issues one pulse per qualified press, then enforces a post-release holdoff.
module clr_req_qualifier #(
  parameter int DEB_CYCLES     = 4,
  parameter int HOLDOFF_CYCLES = 8,
  parameter int CNT_W          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             raw_in,
  input  logic             en,
  output logic             pulse_out,
  output logic             level,
  output logic             busy,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CONFIRM, ACTIVE, HOLDOFF} state_t;

  state_t          state;
  logic [1:0]      sync;
  logic            s;
  logic [DW-1:0]   press_cnt;
  logic [DW-1:0]   rel_cnt;
  logic [HW-1:0]   hold_cnt;

  always_ff @(posedge clk) begin
    if (rst) sync <= 2'b00;
    else     sync <= {sync[0], raw_in};
  end

  assign s = sync[1];

  // level/busy are written alongside every state change so they always
  // reflect the state register without a decode stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      press_cnt <= '0;
      rel_cnt   <= '0;
      hold_cnt  <= '0;
      pulse_out <= 1'b0;
      level     <= 1'b0;
      busy      <= 1'b0;
      evt_cnt   <= '0;
    end else begin
      pulse_out <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        press_cnt <= '0;
        rel_cnt   <= '0;
        hold_cnt  <= '0;
        level     <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (s) begin
              state     <= CONFIRM;
              press_cnt <= DW'(1);
              busy      <= 1'b1;
            end
          end
          CONFIRM: begin
            if (!s) begin
              state     <= IDLE;
              press_cnt <= '0;
              busy      <= 1'b0;
            end else if (press_cnt == DEB_LAST) begin
              state     <= ACTIVE;
              press_cnt <= '0;
              rel_cnt   <= '0;
              pulse_out <= 1'b1;
              level     <= 1'b1;
              evt_cnt   <= evt_cnt + CNT_W'(1);
            end else begin
              press_cnt <= press_cnt + DW'(1);
            end
          end
          ACTIVE: begin
            if (s) begin
              rel_cnt <= '0;
            end else if (rel_cnt == DEB_LAST) begin
              state    <= HOLDOFF;
              rel_cnt  <= '0;
              hold_cnt <= '0;
              level    <= 1'b0;
            end else begin
              rel_cnt <= rel_cnt + DW'(1);
            end
          end
          HOLDOFF: begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= IDLE;
              hold_cnt <= '0;
              busy     <= 1'b0;
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          default: begin
            state <= IDLE;
            level <= 1'b0;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clr_req_qualifier.sv
// Randomised bench for clr_req_qualifier against a run-length reference model,
// plus directed scenarios with literal expectations.
module tb_clr_req_qualifier;
  localparam int DEB  = 4;
  localparam int HOLD = 8;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          raw_in = 1'b0;
  logic          en = 1'b1;
  logic          pulse_out, level, busy;
  logic [CW-1:0] evt_cnt;

  int tests = 0;
  int fails = 0;
  bit cmp_on = 1'b0;

  clr_req_qualifier #(.DEB_CYCLES(DEB), .HOLDOFF_CYCLES(HOLD), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .raw_in(raw_in), .en(en),
    .pulse_out(pulse_out), .level(level), .busy(busy), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: tracks run lengths of the synchronised request and a
  // holdoff countdown, rather than an explicit state machine.
  bit m_s1, m_s2;
  int hi_run, lo_run, hold_left, m_cnt;
  bit m_active, m_pulse;

  always @(posedge clk) begin
    bit sv;
    sv = m_s2;
    m_pulse = 1'b0;
    if (rst) begin
      m_s1 = 0; m_s2 = 0; hi_run = 0; lo_run = 0; hold_left = 0;
      m_active = 0; m_cnt = 0;
    end else begin
      m_s2 = m_s1; m_s1 = raw_in;
      if (!en) begin
        hi_run = 0; lo_run = 0; hold_left = 0; m_active = 0;
      end else if (hold_left > 0) begin
        hold_left--;
      end else if (m_active) begin
        lo_run = sv ? 0 : lo_run + 1;
        if (lo_run == DEB) begin
          m_active = 0; lo_run = 0; hold_left = HOLD;
        end
      end else if (sv) begin
        hi_run++;
        if (hi_run == DEB) begin
          m_active = 1; hi_run = 0; m_pulse = 1;
          m_cnt = (m_cnt + 1) % (1 << CW);
        end
      end else begin
        hi_run = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      logic exp_busy;
      exp_busy = m_active || hold_left > 0 || hi_run > 0;
      tests++;
      if (pulse_out !== m_pulse || level !== m_active || busy !== exp_busy ||
          evt_cnt !== CW'(m_cnt)) begin
        fails++;
        $display("FAIL model_cmp t=%0t got p/l/b/c=%b/%b/%b/%0d want %b/%b/%b/%0d",
                 $time, pulse_out, level, busy, evt_cnt, m_pulse, m_active, exp_busy, m_cnt);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic press_release();
    raw_in = 1'b1; step(8);
    raw_in = 1'b0; step(16);
  endtask

  initial begin
    // 1: reset
    rst = 1'b1; en = 1'b1; raw_in = 1'b0;
    step(3);
    cmp_on = 1'b1;
    chk("rst_pulse", int'(pulse_out), 0);
    chk("rst_cnt", int'(evt_cnt), 0);
    rst = 1'b0;
    step(4);
    chk("idle_busy", int'(busy), 0);
    chk("idle_level", int'(level), 0);

    // 2: press latency -- raw sampled at edge k, pulse after edge k+5
    raw_in = 1'b1;
    step(5);
    chk("lat_early", int'(pulse_out), 0);
    step(1);
    chk("lat_pulse", int'(pulse_out), 1);
    chk("lat_level", int'(level), 1);
    chk("lat_cnt", int'(evt_cnt), 1);
    step(1);
    chk("pulse_width", int'(pulse_out), 0);
    chk("level_hold", int'(level), 1);
    raw_in = 1'b0;
    step(20);
    chk("after_hold_busy", int'(busy), 0);

    // 3: short press (3 samples) aborts
    raw_in = 1'b1; step(3);
    raw_in = 1'b0; step(10);
    chk("short_busy", int'(busy), 0);
    chk("short_cnt", int'(evt_cnt), 1);

    // 4: release, bounce during holdoff, then hold high past holdoff
    raw_in = 1'b1; step(10);
    chk("press2_cnt", int'(evt_cnt), 2);
    raw_in = 1'b0; step(4);
    for (int i = 0; i < 6; i++) begin
      raw_in = 1'($urandom_range(0, 1));
      step(1);
    end
    raw_in = 1'b1;
    step(3);
    chk("holdoff_busy", int'(busy), 1);
    chk("holdoff_cnt", int'(evt_cnt), 2);
    step(20);
    chk("repress_cnt", int'(evt_cnt), 3);
    raw_in = 1'b0; step(20);

    // 5: wrap after 16 presses total, then en drop mid-confirm
    for (int i = 0; i < 13; i++) press_release();
    chk("wrap_cnt", int'(evt_cnt), 0);
    raw_in = 1'b1; step(4);
    chk("confirm_busy", int'(busy), 1);
    en = 1'b0; step(1);
    chk("en_busy", int'(busy), 0);
    step(8);
    chk("en_cnt", int'(evt_cnt), 0);
    raw_in = 1'b0; en = 1'b1; step(10);

    // 6: reset on the qualifying edge drops the pulse
    press_release();
    chk("pre_rst_cnt", int'(evt_cnt), 1);
    raw_in = 1'b1; step(5);
    rst = 1'b1; step(1);
    chk("rst_q_pulse", int'(pulse_out), 0);
    chk("rst_q_cnt", int'(evt_cnt), 0);
    chk("rst_q_busy", int'(busy), 0);
    rst = 1'b0; raw_in = 1'b0; step(4);

    // random phase: variable run lengths, occasional en drops and resets
    for (int i = 0; i < 400; i++) begin
      int len;
      raw_in = 1'($urandom_range(0, 1));
      en     = ($urandom_range(0, 19) != 0);
      rst    = ($urandom_range(0, 99) == 0);
      len    = $urandom_range(1, 12);
      step(1);
      rst = 1'b0;
      step(len - 1);
    end
    en = 1'b1; raw_in = 1'b0; step(30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
